of_stage_fwd: RTL and testbench
===============================

# of_stage_fwd

Parametrised operand-fetch (OF) stage for the in-order 5-stage pipeline. It sits between the IF→OF and OF→EX pipeline registers and contains the GPR file, read-address steering, the immediate generator and the OF→EX register. It adds a valid/ready handshake, flush, load-use interlock and optional EX/MA result forwarding.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- NREGS, 16: GPR count; power of two, 2..16. AW = $clog2(NREGS). Register NREGS-1 is RA.
- CTRL_W, 16: width of the opaque control bundle passed through to EX.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  kill the instruction in OF and in the OF→EX register (taken branch).
- in_valid  in  1  an IF→OF instruction is presented.
- in_ready  out  1  OF accepts the instruction this cycle.
- in_pc  in  XLEN  PC of the presented instruction.
- in_instr  in  32  instruction word: op[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14], mod[17:16], imm[15:0].
- in_ctrl  in  CTRL_W  control-unit bundle for this instruction.
- dec  in  6  decode bits {use_rs2, use_rs1, is_imm, is_call, is_ret, is_st} (bit 0 = is_st).
- wb_en / wb_addr / wb_data  in  1 / AW / XLEN  RW-stage register write.
- ex_dst_valid / ex_dst_addr / ex_is_ld  in  1 / AW / 1  destination of the instruction in EX.
- ex_data  in  XLEN  EX result (ALU output, or PC+4 for call).
- ma_dst_valid / ma_dst_addr  in  1 / AW  destination of the instruction in MA.
- ma_data  in  XLEN  MA result (load data or ALU result).
- out_valid  out  1  OF→EX register holds a live instruction.
- out_ready  in  1  EX accepts.
- out_pc  out  XLEN  captured PC.
- out_op1 / out_op2  out  XLEN  ALU operands; op2 = immx if is_imm, else the rs2 value.
- out_st_data  out  XLEN  rs2-port value (rd for stores).
- out_rd  out  AW  write destination: NREGS-1 if is_call, else rd.
- out_ctrl  out  CTRL_W  captured in_ctrl.

## Operation
- Read addresses: ra1 = is_ret ? NREGS-1 : rs1[AW-1:0]. ra2 = is_st ? rd[AW-1:0] : rs2[AW-1:0]. Field bits above AW are ignored.
- GPR file: NREGS×XLEN flops, all zero at reset. Written on a clock edge when wb_en is set. There is no hardwired zero register.
- Operand source priority: EX (when ex_dst_valid, address match and !ex_is_ld), then MA (ma_dst_valid and match), then WB write-through (wb_en and match), then the array.
- immx by mod: 00 = sign-extend imm[15:0]; 01 = zero-extend; 10 = imm[15:0]<<16, sign-extended from bit 31; 11 = zero-extend.
- Hazard is asserted when in_valid and (use_rs1 and ra1 matches a blocking source, or use_rs2 and ra2 matches a blocking source). The blocking sources depend on configuration.
- in_ready = flush | (!hazard & (out_ready | !out_valid)).
- Register update:
  - flush → out_valid=0.
  - Else, if out_ready or !out_valid: capture all outputs; out_valid = in_valid & !hazard.
  - Else: hold.
- While a hazard is present, the OF→EX register loads a bubble. Operands are re-read every cycle until the hazard clears.

## Timing
- Reset: out_valid=0; out_pc, out_op1, out_op2, out_st_data, out_rd, out_ctrl all 0; GPRs 0. Reset asserted mid-stall or mid-flush discards everything with no partial state.
- OF latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N.
- Operand read, forwarding, immediate generation and in_ready are combinational within the cycle.
- A WB write and a dependent OF read in the same cycle yield the new value (write-through); the array updates at the same edge.
- flush wins over stall and backpressure. An instruction offered during flush is consumed and discarded.
- Outputs are stable while out_valid & !out_ready.

## Configuration
- OF_FWD_EN defined:
  - EX/MA forwarding is active.
  - The only blocking source is EX holding a load (ex_is_ld) with a matching destination. This gives exactly a 1-cycle load-use stall.
- OF_FWD_EN undefined:
  - No EX/MA forwarding; only WB write-through remains.
  - Any matching valid EX or MA destination blocks. A back-to-back ALU dependency stalls 2 cycles.

## Test plan
- Reset, then read r3 with no writes → out_op1=0, out_valid=0 until the first accepted instruction.
- wb_en writes r5=0xDEADBEEF while a same-cycle instruction reads r5 → out_op1=0xDEADBEEF, no stall.
- EX ALU dest r2=0x10, next instruction reads r2:
  - With OF_FWD_EN: out_op1=0x10, zero stalls.
  - Without OF_FWD_EN: in_ready=0 for 2 cycles, then the value arrives via WB.
- EX load into r4, next instruction `add r1,r4,r4` → in_ready=0 for 1 cycle, then out_op1=out_op2=MA load data (OF_FWD_EN).
- imm=0x8001 with mod=00/01/10/11 → immx=0xFFFF8001 / 0x00008001 / 0x80010000 / 0x00008001 (XLEN=32).
- out_ready=0 for 3 cycles with flush on cycle 2 → outputs held on cycle 1; out_valid=0 after the cycle-2 edge; the in-flight instruction is dropped.

Source files
------------

// File: rtl/of_stage_fwd.sv
// ---------------------------------------------------------------------------
// of_stage_fwd -- operand-fetch stage of the in-order 5-stage pipeline.
//
// Sits between the IF->OF and OF->EX pipeline registers. Holds the GPR file,
// steers the read addresses, generates the immediate, resolves operands
// (forwarding / write-through) and owns the OF->EX register with a
// valid/ready handshake, flush and load-use interlock.
//
// Build option:
//   OF_FWD_EN  defined   : EX/MA results forwarded into OF; only a load in EX
//                          with a matching destination stalls (1 cycle).
//              undefined : WB write-through only; any valid matching EX or MA
//                          destination stalls.
//
// Parameters: XLEN (32|64), NREGS (power of two, 2..16, reg NREGS-1 = RA),
//             CTRL_W (opaque control bundle width).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   flush_i                  kill instruction in OF and in the OF->EX register
//   in_valid_i / in_ready_o  IF->OF handshake (in_ready_o is combinational)
//   in_pc_i, in_instr_i,
//   in_ctrl_i, dec_i         presented instruction, control bundle, decode
//                            bits {use_rs2,use_rs1,is_imm,is_call,is_ret,is_st}
//   wb_en_i/wb_addr_i/wb_data_i          RW-stage register write
//   ex_dst_valid_i/ex_dst_addr_i/ex_is_ld_i/ex_data_i   EX destination/result
//   ma_dst_valid_i/ma_dst_addr_i/ma_data_i              MA destination/result
//   out_valid_o / out_ready_i            OF->EX handshake
//   out_pc_o, out_op1_o, out_op2_o,
//   out_st_data_o, out_rd_o, out_ctrl_o  registered OF->EX payload
// ---------------------------------------------------------------------------
module of_stage_fwd #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned CTRL_W = 16,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              flush_i,

  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   in_pc_i,
  input  logic [31:0]       in_instr_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [5:0]        dec_i,

  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,

  input  logic              ex_dst_valid_i,
  input  logic [AW-1:0]     ex_dst_addr_i,
  input  logic              ex_is_ld_i,
  input  logic [XLEN-1:0]   ex_data_i,

  input  logic              ma_dst_valid_i,
  input  logic [AW-1:0]     ma_dst_addr_i,
  input  logic [XLEN-1:0]   ma_data_i,

  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [XLEN-1:0]   out_op1_o,
  output logic [XLEN-1:0]   out_op2_o,
  output logic [XLEN-1:0]   out_st_data_o,
  output logic [AW-1:0]     out_rd_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 16;
  localparam logic [AW-1:0] RA_IDX = AW'(NREGS - 1);

  // Instruction fields and decode bits
  logic [FIELD_W-1:0] rd_f;
  logic [FIELD_W-1:0] rs1_f;
  logic [FIELD_W-1:0] rs2_f;
  logic [1:0]         mod_f;
  logic [IMM_W-1:0]   imm_f;
  logic use_rs2, use_rs1, is_imm, is_call, is_ret, is_st;

  assign rd_f  = in_instr_i[25:22];
  assign rs1_f = in_instr_i[21:18];
  assign rs2_f = in_instr_i[17:14];
  assign mod_f = in_instr_i[17:16];
  assign imm_f = in_instr_i[15:0];
  assign {use_rs2, use_rs1, is_imm, is_call, is_ret, is_st} = dec_i;

  // Register file
  logic [XLEN-1:0] gpr_q [NREGS];

  // Combinational operand path
  logic [AW-1:0]   ra1_c;
  logic [AW-1:0]   ra2_c;
  logic [XLEN-1:0] rs1_val_c;
  logic [XLEN-1:0] rs2_val_c;
  logic [XLEN-1:0] immx_c;
  logic            hazard_c;
  logic            load_en_c;

  // OF->EX register
  logic              out_valid_q,   out_valid_d;
  logic [XLEN-1:0]   out_pc_q,      out_pc_d;
  logic [XLEN-1:0]   out_op1_q,     out_op1_d;
  logic [XLEN-1:0]   out_op2_q,     out_op2_d;
  logic [XLEN-1:0]   out_st_data_q, out_st_data_d;
  logic [AW-1:0]     out_rd_q,      out_rd_d;
  logic [CTRL_W-1:0] out_ctrl_q,    out_ctrl_d;

  // Operand value for one read port: youngest producer wins, array last.
  function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0]   a,
                                              input logic [XLEN-1:0] arr_v);
    logic [XLEN-1:0] v;
    v = arr_v;
    if (wb_en_i && (wb_addr_i == a)) v = wb_data_i;
`ifdef OF_FWD_EN
    if (ma_dst_valid_i && (ma_dst_addr_i == a)) v = ma_data_i;
    if (ex_dst_valid_i && !ex_is_ld_i && (ex_dst_addr_i == a)) v = ex_data_i;
`endif
    return v;
  endfunction

  // True when a read of address a cannot be satisfied this cycle.
  function automatic logic blocks(input logic [AW-1:0] a);
`ifdef OF_FWD_EN
    return ex_dst_valid_i && ex_is_ld_i && (ex_dst_addr_i == a);
`else
    return (ex_dst_valid_i && (ex_dst_addr_i == a)) ||
           (ma_dst_valid_i && (ma_dst_addr_i == a));
`endif
  endfunction

  // Read-address steering: ret reads RA, store reads rd on port 2
  always_comb begin
    ra1_c = rs1_f[AW-1:0];
    ra2_c = rs2_f[AW-1:0];
    if (is_ret) ra1_c = RA_IDX;
    if (is_st)  ra2_c = rd_f[AW-1:0];
  end

  // Operand resolution
  always_comb begin
    rs1_val_c = resolve(ra1_c, gpr_q[ra1_c]);
    rs2_val_c = resolve(ra2_c, gpr_q[ra2_c]);
  end

  // Immediate generator
  always_comb begin
    immx_c = XLEN'(imm_f);
    unique case (mod_f)
      2'b00:   immx_c = XLEN'($signed(imm_f));
      2'b10:   immx_c = XLEN'($signed({imm_f, 16'h0000}));
      default: immx_c = XLEN'(imm_f);
    endcase
  end

  // Interlock and handshake
  always_comb begin
    hazard_c   = in_valid_i && ((use_rs1 && blocks(ra1_c)) ||
                                (use_rs2 && blocks(ra2_c)));
    load_en_c  = out_ready_i || !out_valid_q;
    in_ready_o = flush_i || (!hazard_c && load_en_c);
  end

  // GPR array: no hardwired zero register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) gpr_q[i] <= '0;
    end else if (wb_en_i) begin
      gpr_q[wb_addr_i] <= wb_data_i;
    end
  end

  // OF->EX next state; a stalled cycle loads a bubble with current operands
  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    out_st_data_d = out_st_data_q;
    out_rd_d      = out_rd_q;
    out_ctrl_d    = out_ctrl_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (load_en_c) begin
      out_valid_d   = in_valid_i && !hazard_c;
      out_pc_d      = in_pc_i;
      out_op1_d     = rs1_val_c;
      out_op2_d     = is_imm ? immx_c : rs2_val_c;
      out_st_data_d = rs2_val_c;
      out_rd_d      = is_call ? RA_IDX : rd_f[AW-1:0];
      out_ctrl_d    = in_ctrl_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_st_data_q <= '0;
      out_rd_q      <= '0;
      out_ctrl_q    <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_op1_q     <= out_op1_d;
      out_op2_q     <= out_op2_d;
      out_st_data_q <= out_st_data_d;
      out_rd_q      <= out_rd_d;
      out_ctrl_q    <= out_ctrl_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_pc_o      = out_pc_q;
  assign out_op1_o     = out_op1_q;
  assign out_op2_o     = out_op2_q;
  assign out_st_data_o = out_st_data_q;
  assign out_rd_o      = out_rd_q;
  assign out_ctrl_o    = out_ctrl_q;

  // Opcode/I bits belong to decode; upper field bits are unused when AW < 4
  logic unused_c;
`ifdef OF_FWD_EN
  assign unused_c = ^{in_instr_i[31:26], rd_f, rs1_f, rs2_f};
`else
  assign unused_c = ^{in_instr_i[31:26], rd_f, rs1_f, rs2_f,
                      ex_is_ld_i, ex_data_i, ma_data_i};
`endif

endmodule

// File: tb/tb_of_stage_fwd.sv
// ---------------------------------------------------------------------------
// tb_of_stage_fwd -- directed bench for of_stage_fwd (XLEN=32, NREGS=16).
// Inputs change 1 time unit after a rising edge; in_ready is checked 1 unit
// later, registered outputs 1 unit after the following rising edge.
// Works in both builds; expectations that differ are selected by OF_FWD_EN.
// ---------------------------------------------------------------------------
module tb_of_stage_fwd;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned AW     = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_instr;
  logic [CTRL_W-1:0] in_ctrl;
  logic [5:0]        dec;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ex_dst_valid;
  logic [AW-1:0]     ex_dst_addr;
  logic              ex_is_ld;
  logic [XLEN-1:0]   ex_data;
  logic              ma_dst_valid;
  logic [AW-1:0]     ma_dst_addr;
  logic [XLEN-1:0]   ma_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_op1;
  logic [XLEN-1:0]   out_op2;
  logic [XLEN-1:0]   out_st_data;
  logic [AW-1:0]     out_rd;
  logic [CTRL_W-1:0] out_ctrl;

  int errors = 0;
  int checks = 0;

  // dec = {use_rs2, use_rs1, is_imm, is_call, is_ret, is_st}
  localparam logic [5:0] D_RR   = 6'b110000;
  localparam logic [5:0] D_RS1  = 6'b010000;
  localparam logic [5:0] D_IMM  = 6'b011000;
  localparam logic [5:0] D_RET  = 6'b010010;
  localparam logic [5:0] D_ST   = 6'b110001;
  localparam logic [5:0] D_CALL = 6'b000100;

  of_stage_fwd #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pc_i(in_pc),
    .in_instr_i(in_instr), .in_ctrl_i(in_ctrl), .dec_i(dec),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ex_dst_valid_i(ex_dst_valid), .ex_dst_addr_i(ex_dst_addr),
    .ex_is_ld_i(ex_is_ld), .ex_data_i(ex_data),
    .ma_dst_valid_i(ma_dst_valid), .ma_dst_addr_i(ma_dst_addr),
    .ma_data_i(ma_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_op1_o(out_op1), .out_op2_o(out_op2), .out_st_data_o(out_st_data),
    .out_rd_o(out_rd), .out_ctrl_o(out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2);
    return {6'b0, rd, rs1, rs2, 14'b0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [1:0] mod, input logic [15:0] imm);
    return {6'b0, rd, rs1, mod, imm};
  endfunction

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_ctrl = '0;
    dec = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_dst_valid = 1'b0; ex_dst_addr = '0; ex_is_ld = 1'b0; ex_data = '0;
    ma_dst_valid = 1'b0; ma_dst_addr = '0; ma_data = '0; out_ready = 1'b1;
  endtask

  task automatic issue(input logic [XLEN-1:0] pc, input logic [31:0] instr,
                       input logic [5:0] d, input logic [CTRL_W-1:0] ctrl);
    in_valid = 1'b1; in_pc = pc; in_instr = instr; dec = d; in_ctrl = ctrl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", out_pc); end
    checks++; if (out_op1 !== 32'h0) begin errors++; $display("FAIL reset_op1: got %h exp 0", out_op1); end
    checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl: got %h exp 0", out_ctrl); end
    rst = 1'b1;
    next_cycle();
    issue(32'h40, mk_r(4'd1, 4'd3, 4'd0), D_RS1, 16'h1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_valid_pre: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b exp 1", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b exp 1", out_valid); end
    checks++; if (out_op1 !== 32'h0) begin errors++; $display("FAIL read_r3: got %h exp 0", out_op1); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL first_pc: got %h exp 40", out_pc); end
  endtask

  task automatic test_wb_through();
    idle();
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    issue(32'h44, mk_r(4'd1, 4'd5, 4'd5), D_RR, 16'h2);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wbt_ready: got %b exp 1", in_ready); end
    next_cycle();
    checks++; if (out_op1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wbt_op1: got %h exp deadbeef", out_op1); end
    checks++; if (out_st_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wbt_st: got %h exp deadbeef", out_st_data); end
    wb_en = 1'b0; in_pc = 32'h48;
    next_cycle();
    checks++; if (out_op1 !== 32'hDEADBEEF) begin errors++; $display("FAIL array_r5: got %h exp deadbeef", out_op1); end
  endtask

  task automatic test_ex_dep();
    idle();
    ex_dst_valid = 1'b1; ex_dst_addr = 4'd2; ex_data = 32'h10;
    issue(32'h50, mk_r(4'd3, 4'd2, 4'd0), D_RS1, 16'h3);
    #1;
`ifdef OF_FWD_EN
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exdep_ready: got %b exp 1", in_ready); end
    next_cycle();
`else
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exdep_stall1: got %b exp 0", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exdep_bubble1: got %b exp 0", out_valid); end
    ex_dst_valid = 1'b0; ma_dst_valid = 1'b1; ma_dst_addr = 4'd2; ma_data = 32'h10;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exdep_stall2: got %b exp 0", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exdep_bubble2: got %b exp 0", out_valid); end
    ma_dst_valid = 1'b0; wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h10;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exdep_release: got %b exp 1", in_ready); end
    next_cycle();
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL exdep_valid: got %b exp 1", out_valid); end
    checks++; if (out_op1 !== 32'h10) begin errors++; $display("FAIL exdep_op1: got %h exp 10", out_op1); end
  endtask

`ifdef OF_FWD_EN
  task automatic test_fwd_priority();
    idle();
    ex_dst_valid = 1'b1; ex_dst_addr = 4'd7; ex_data = 32'h77;
    ma_dst_valid = 1'b1; ma_dst_addr = 4'd7; ma_data = 32'h88;
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h99;
    issue(32'h58, mk_r(4'd1, 4'd7, 4'd0), D_RS1, 16'h4);
    next_cycle();
    checks++; if (out_op1 !== 32'h77) begin errors++; $display("FAIL prio_ex: got %h exp 77", out_op1); end
    ex_dst_valid = 1'b0;
    next_cycle();
    checks++; if (out_op1 !== 32'h88) begin errors++; $display("FAIL prio_ma: got %h exp 88", out_op1); end
    ma_dst_valid = 1'b0;
    next_cycle();
    checks++; if (out_op1 !== 32'h99) begin errors++; $display("FAIL prio_wb: got %h exp 99", out_op1); end
  endtask
`endif

  task automatic test_load_use();
    idle();
    ex_dst_valid = 1'b1; ex_dst_addr = 4'd4; ex_is_ld = 1'b1; ex_data = 32'hBAD;
    issue(32'h60, mk_r(4'd1, 4'd4, 4'd4), D_RR, 16'h5);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_stall: got %b exp 0", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_bubble: got %b exp 0", out_valid); end
    ex_dst_valid = 1'b0; ex_is_ld = 1'b0;
    ma_dst_valid = 1'b1; ma_dst_addr = 4'd4; ma_data = 32'hCAFE0004;
    #1;
`ifdef OF_FWD_EN
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_release: got %b exp 1", in_ready); end
`else
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_stall_ma: got %b exp 0", in_ready); end
    next_cycle();
    ma_dst_valid = 1'b0; wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'hCAFE0004;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_release: got %b exp 1", in_ready); end
`endif
    next_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ld_valid: got %b exp 1", out_valid); end
    checks++; if (out_op1 !== 32'hCAFE0004) begin errors++; $display("FAIL ld_op1: got %h exp cafe0004", out_op1); end
    checks++; if (out_op2 !== 32'hCAFE0004) begin errors++; $display("FAIL ld_op2: got %h exp cafe0004", out_op2); end
  endtask

  task automatic test_imm();
    logic [31:0] exp_t [4];
    exp_t[0] = 32'hFFFF8001;
    exp_t[1] = 32'h00008001;
    exp_t[2] = 32'h80010000;
    exp_t[3] = 32'h00008001;
    for (int m = 0; m < 4; m++) begin
      idle();
      issue(32'h70, mk_i(4'd1, 4'd0, 2'(m), 16'h8001), D_IMM, 16'h6);
      next_cycle();
      checks++;
      if (out_op2 !== exp_t[m]) begin
        errors++; $display("FAIL imm_mod%0d: got %h exp %h", m, out_op2, exp_t[m]);
      end
    end
  endtask

  task automatic test_steer();
    idle();
    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h15151515;
    next_cycle();
    wb_addr = 4'd9; wb_data = 32'h99;
    next_cycle();
    idle();
    issue(32'h80, mk_r(4'd0, 4'd3, 4'd0), D_RET, 16'h7);
    next_cycle();
    checks++; if (out_op1 !== 32'h15151515) begin errors++; $display("FAIL ret_ra: got %h exp 15151515", out_op1); end
    issue(32'h84, mk_r(4'd9, 4'd3, 4'd2), D_ST, 16'h8);
    next_cycle();
    checks++; if (out_st_data !== 32'h99) begin errors++; $display("FAIL st_data: got %h exp 99", out_st_data); end
    checks++; if (out_op2 !== 32'h99) begin errors++; $display("FAIL st_op2: got %h exp 99", out_op2); end
    checks++; if (out_rd !== 4'd9) begin errors++; $display("FAIL st_rd: got %0d exp 9", out_rd); end
    issue(32'h88, mk_r(4'd6, 4'd0, 4'd0), D_CALL, 16'hC0DE);
    next_cycle();
    checks++; if (out_rd !== 4'd15) begin errors++; $display("FAIL call_rd: got %0d exp 15", out_rd); end
    checks++; if (out_ctrl !== 16'hC0DE) begin errors++; $display("FAIL call_ctrl: got %h exp c0de", out_ctrl); end
  endtask

  task automatic test_backpressure_flush();
    idle();
    issue(32'h100, mk_r(4'd1, 4'd0, 4'd0), 6'b000000, 16'h000A);
    next_cycle();
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL bp_a_pc: got %h exp 100", out_pc); end
    out_ready = 1'b0;
    issue(32'h200, mk_r(4'd2, 4'd0, 4'd0), 6'b000000, 16'h000B);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b exp 0", in_ready); end
    next_cycle();
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL bp_hold_pc: got %h exp 100", out_pc); end
    checks++; if (out_ctrl !== 16'h000A) begin errors++; $display("FAIL bp_hold_ctrl: got %h exp a", out_ctrl); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b exp 1", out_valid); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
    flush = 1'b0;
    issue(32'h300, mk_r(4'd3, 4'd0, 4'd0), 6'b000000, 16'h000C);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready: got %b exp 1", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid: got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h300) begin errors++; $display("FAIL post_flush_pc: got %h exp 300", out_pc); end
    idle();
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    ex_dst_valid = 1'b1; ex_dst_addr = 4'd5; ex_is_ld = 1'b1;
    issue(32'h500, mk_r(4'd1, 4'd5, 4'd0), D_RS1, 16'hE);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_ready: got %b exp 0", in_ready); end
    #1 rst = 1'b0;
    #1;
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_async_pc: got %h exp 0", out_pc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b exp 0", out_valid); end
    #1 rst = 1'b1;
    idle();
    next_cycle();
    issue(32'h504, mk_r(4'd1, 4'd5, 4'd0), D_RS1, 16'hF);
    next_cycle();
    checks++; if (out_op1 !== 32'h0) begin errors++; $display("FAIL rst_gpr_clear: got %h exp 0", out_op1); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_resume_valid: got %b exp 1", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wb_through();
    test_ex_dep();
`ifdef OF_FWD_EN
    test_fwd_priority();
`endif
    test_load_use();
    test_imm();
    test_steer();
    test_backpressure_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
